// File: rtl/hub75_scan.sv
// HUB75 scan/modulation stage: fetches pixels, shifts one BCM bitplane per row pass,
// latches it and holds output enable low for a time weighted by the bitplane index.
module hub75_scan #(
    parameter int hpixel_p   = 64,
    parameter int vpixel_p   = 64,
    parameter int bpp_p      = 8,
    parameter int segments_p = 2,
    parameter int oe_base_p  = 4,
    localparam int rows_p       = vpixel_p / segments_p,
    localparam int row_w_p      = $clog2(rows_p),
    localparam int addr_width_p = $clog2(hpixel_p * vpixel_p)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_en,
    output logic [addr_width_p-1:0]         o_rd_addr,
    input  logic [segments_p*3*bpp_p-1:0]   i_rd_data,
    output logic [segments_p*3-1:0]         o_rgb,
    output logic                            o_clk,
    output logic                            o_lat,
    output logic                            o_oe,
    output logic [row_w_p-1:0]              o_addr,
    output logic                            o_frame_sync
);

    localparam int col_w_p  = $clog2(hpixel_p + 1);
    localparam int bit_w_p  = $clog2(bpp_p);
    localparam int disp_w_p = $clog2((oe_base_p << (bpp_p - 1)) + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_LATCH   = 2'd2;
    localparam logic [1:0] ST_DISPLAY = 2'd3;

    logic [1:0]                           state;
    logic [col_w_p-1:0]                   col;
    logic                                 phase;
    logic [row_w_p-1:0]                   row;
    logic [bit_w_p-1:0]                   b;
    logic [disp_w_p-1:0]                  disp_cnt;
    logic [disp_w_p-1:0]                  disp_load;
    logic                                 last_row;
    logic                                 last_bit;
    logic [segments_p*3-1:0][bpp_p-1:0]   pix;
    logic [segments_p*3-1:0]              plane;

    // View the read word as [seg*3+ch][bit] and pick the current bitplane.
    assign pix = i_rd_data;
    for (genvar g = 0; g < segments_p * 3; g++) begin : g_plane
        assign plane[g] = pix[g][b];
    end

    assign last_row  = (row == row_w_p'(rows_p - 1));
    assign last_bit  = (b == bit_w_p'(bpp_p - 1));
    assign disp_load = disp_w_p'(oe_base_p << b);

    // Each SHIFT cycle is 2*col+phase; all outputs are registered for the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            col          <= '0;
            phase        <= 1'b0;
            row          <= '0;
            b            <= '0;
            disp_cnt     <= '0;
            o_rd_addr    <= '0;
            o_rgb        <= '0;
            o_clk        <= 1'b0;
            o_lat        <= 1'b0;
            o_oe         <= 1'b1;
            o_addr       <= '0;
            o_frame_sync <= 1'b0;
        end else begin
            o_clk        <= 1'b0;
            o_lat        <= 1'b0;
            o_frame_sync <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_oe <= 1'b1;
                    if (i_en) begin
                        state     <= ST_SHIFT;
                        row       <= '0;
                        b         <= '0;
                        col       <= '0;
                        phase     <= 1'b0;
                        o_rd_addr <= '0;
                    end
                end
                ST_SHIFT: begin
                    phase <= ~phase;
                    if (phase) begin
                        col <= col + col_w_p'(1);
                    end
                    if (phase && col < col_w_p'(hpixel_p - 1)) begin
                        o_rd_addr <= addr_width_p'(int'(row) * hpixel_p + int'(col) + 1);
                    end
                    if (phase && col < col_w_p'(hpixel_p)) begin
                        o_rgb <= plane;
                    end
                    o_clk <= ~phase && (col != '0);
                    if (phase && col == col_w_p'(hpixel_p)) begin
                        state  <= ST_LATCH;
                        o_lat  <= 1'b1;
                        o_addr <= row;
                    end
                end
                ST_LATCH: begin
                    state    <= ST_DISPLAY;
                    o_oe     <= 1'b0;
                    disp_cnt <= disp_load - disp_w_p'(1);
                    if (disp_load == disp_w_p'(1) && last_row && last_bit) begin
                        o_frame_sync <= 1'b1;
                    end
                end
                ST_DISPLAY: begin
                    if (disp_cnt == '0) begin
                        o_oe  <= 1'b1;
                        col   <= '0;
                        phase <= 1'b0;
                        if (!i_en) begin
                            state <= ST_IDLE;
                            row   <= '0;
                            b     <= '0;
                        end else begin
                            state <= ST_SHIFT;
                            if (!last_bit) begin
                                b         <= b + bit_w_p'(1);
                                o_rd_addr <= addr_width_p'(int'(row) * hpixel_p);
                            end else begin
                                b <= '0;
                                if (last_row) begin
                                    row       <= '0;
                                    o_rd_addr <= '0;
                                end else begin
                                    row       <= row + row_w_p'(1);
                                    o_rd_addr <= addr_width_p'((int'(row) + 1) * hpixel_p);
                                end
                            end
                        end
                    end else begin
                        disp_cnt <= disp_cnt - disp_w_p'(1);
                        if (disp_cnt == disp_w_p'(1) && last_row && last_bit) begin
                            o_frame_sync <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_scan.sv
// Directed bench for hub75_scan: pixel source model plus per-bitplane observation of
// the panel pins, compared against hand-derived timing and colour values.
module tb_hub75_scan;

    logic        clk;
    logic        rst;
    logic        i_en;
    logic [11:0] o_rd_addr;
    logic [47:0] i_rd_data;
    logic [5:0]  o_rgb;
    logic        o_clk;
    logic        o_lat;
    logic        o_oe;
    logic [4:0]  o_addr;
    logic        o_frame_sync;

    int pattern_sel;
    int cycle_no;
    int check_count;
    int pass_count;
    int drop_at;

    int rises, lat_cyc, lat_cnt, lat_addr, lat_oe_low, oe_low, disp_addr;
    int sync_cnt, sync_cyc, sync_c, addr0, addr20, addr127;
    int rgb_at [64];
    bit sync_last;
    int frame_start, frame_syncs, nonzero, idle_rises;
    logic prev;

    hub75_scan dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (i_en),
        .o_rd_addr    (o_rd_addr),
        .i_rd_data    (i_rd_data),
        .o_rgb        (o_rgb),
        .o_clk        (o_clk),
        .o_lat        (o_lat),
        .o_oe         (o_oe),
        .o_addr       (o_addr),
        .o_frame_sync (o_frame_sync)
    );

    // Word layout is [seg][ch][bit]; corner pattern only sets bit 7 of a channel.
    function automatic logic [47:0] pixelData(input logic [11:0] a, input int sel);
        logic [47:0] d;
        d = '0;
        if (sel == 0) begin
            d = '1;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (a == 12'd0) begin
                    d[s*24+16+7] = 1'b1;
                    d[s*24+8+7]  = 1'b1;
                    d[s*24+7]    = 1'b1;
                end else if (a == 12'd63) begin
                    d[s*24+16+7] = 1'b1;
                end else if (a == 12'd1984) begin
                    d[s*24+8+7] = 1'b1;
                end else if (a == 12'd2047) begin
                    d[s*24+7] = 1'b1;
                end
            end
        end
        return d;
    endfunction

    assign i_rd_data = pixelData(o_rd_addr, pattern_sel);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic waitCycle();
        @(negedge clk);
        cycle_no++;
    endtask

    task automatic applyStimulus(input logic r, input logic e);
        rst  = r;
        i_en = e;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed != expected) begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cycle_no);
        end else begin
            pass_count++;
        end
    endtask

    // Starts on SHIFT cycle 0 and returns on the first cycle after o_oe goes back high.
    task automatic watchPlane();
        logic prev_clk;
        bit   seen_low;
        bit   done;
        int   end_c;
        rises = 0; lat_cyc = -1; lat_cnt = 0; lat_addr = -1; lat_oe_low = 0;
        oe_low = 0; disp_addr = -1; sync_cnt = 0; sync_cyc = -1; sync_c = -1;
        addr0 = int'(o_rd_addr); addr20 = -1; addr127 = -1;
        for (int i = 0; i < 64; i++) rgb_at[i] = -1;
        prev_clk = o_clk;
        seen_low = 1'b0;
        done = 1'b0;
        end_c = -1;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (c == drop_at) applyStimulus(1'b0, 1'b0);
            if (o_clk && !prev_clk) begin
                if (rises < 64) rgb_at[rises] = int'(o_rgb);
                rises++;
            end
            prev_clk = o_clk;
            if (c == 20) addr20 = int'(o_rd_addr);
            if (c == 127) addr127 = int'(o_rd_addr);
            if (o_lat) begin
                lat_cnt++;
                if (lat_cyc < 0) begin
                    lat_cyc  = c;
                    lat_addr = int'(o_addr);
                end
                if (!o_oe) lat_oe_low++;
            end
            if (!o_oe) begin
                oe_low++;
                seen_low = 1'b1;
                disp_addr = int'(o_addr);
            end
            if (o_frame_sync) begin
                sync_cnt++;
                sync_c = c;
                sync_cyc = cycle_no;
            end
            if (seen_low && o_oe) begin
                done = 1'b1;
                end_c = c;
            end else begin
                waitCycle();
            end
        end
        sync_last = (sync_c >= 0 && sync_c == end_c - 1);
        checkOutput("plane_done", int'(done), 1);
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        cycle_no    = 0;
        drop_at     = -1;
        pattern_sel = 0;
        applyStimulus(1'b1, 1'b0);
        repeat (3) waitCycle();
        checkOutput("rst0_oe", int'(o_oe), 1);
        checkOutput("rst0_lat", int'(o_lat), 0);
        checkOutput("rst0_clk", int'(o_clk), 0);
        checkOutput("rst0_rgb", int'(o_rgb), 0);
        checkOutput("rst0_rd_addr", int'(o_rd_addr), 0);
        checkOutput("rst0_sync", int'(o_frame_sync), 0);
        applyStimulus(1'b0, 1'b0);
        repeat (3) waitCycle();

        // First bitplane of row 0 with an all-ones source.
        applyStimulus(1'b0, 1'b1);
        waitCycle();
        frame_start = cycle_no;
        watchPlane();
        frame_syncs = sync_cnt;
        checkOutput("p0_rises", rises, 64);
        for (int k = 0; k < 64; k++) checkOutput($sformatf("p0_rgb%0d", k), rgb_at[k], 6'b111111);
        checkOutput("p0_lat_cycle", lat_cyc, 130);
        checkOutput("p0_lat_count", lat_cnt, 1);
        checkOutput("p0_lat_oe_low", lat_oe_low, 0);
        checkOutput("p0_oe_low", oe_low, 4);
        checkOutput("p0_addr0", addr0, 0);
        checkOutput("p0_addr20", addr20, 10);
        checkOutput("p0_addr127", addr127, 63);

        for (int bp = 1; bp < 8; bp++) begin
            if (bp == 7) pattern_sel = 1;
            watchPlane();
            frame_syncs += sync_cnt;
            checkOutput($sformatf("bcm_oe_b%0d", bp), oe_low, 4 << bp);
            checkOutput($sformatf("bcm_addr_b%0d", bp), disp_addr, 0);
        end
        checkOutput("r0b7_col0", rgb_at[0], 6'b111111);
        checkOutput("r0b7_col63", rgb_at[63], 6'b100100);
        nonzero = 0;
        for (int k = 1; k < 63; k++) if (rgb_at[k] != 0) nonzero++;
        checkOutput("r0b7_mid_zero", nonzero, 0);

        for (int r = 1; r < 32; r++) begin
            for (int bp = 0; bp < 8; bp++) begin
                watchPlane();
                frame_syncs += sync_cnt;
            end
        end
        checkOutput("r31b7_col0", rgb_at[0], 6'b010010);
        checkOutput("r31b7_col63", rgb_at[63], 6'b001001);
        nonzero = 0;
        for (int k = 1; k < 63; k++) if (rgb_at[k] != 0) nonzero++;
        checkOutput("r31b7_mid_zero", nonzero, 0);
        checkOutput("r31b7_addr127", addr127, 2047);
        checkOutput("r31b7_disp_addr", disp_addr, 31);
        checkOutput("r31b7_oe_low", oe_low, 512);
        checkOutput("frame_sync_count", frame_syncs, 1);
        checkOutput("frame_sync_last_oe", int'(sync_last), 1);
        // Pulse lands on the last cycle of a 66176-cycle frame that began at frame_start.
        checkOutput("frame_period", sync_cyc - frame_start, 66175);

        pattern_sel = 0;
        watchPlane();
        checkOutput("wrap_rd_addr", addr0, 0);
        checkOutput("wrap_lat_addr", lat_addr, 0);
        checkOutput("wrap_oe_low", oe_low, 4);
        checkOutput("wrap_no_sync", sync_cnt, 0);

        // Reset while displaying row 0 bitplane 1.
        for (int i = 0; i < 200 && o_oe; i++) waitCycle();
        waitCycle();
        waitCycle();
        checkOutput("pre_rst_oe", int'(o_oe), 0);
        applyStimulus(1'b1, 1'b1);
        waitCycle();
        checkOutput("rst_oe", int'(o_oe), 1);
        checkOutput("rst_lat", int'(o_lat), 0);
        checkOutput("rst_clk", int'(o_clk), 0);
        checkOutput("rst_addr", int'(o_addr), 0);
        checkOutput("rst_rgb", int'(o_rgb), 0);
        checkOutput("rst_rd_addr", int'(o_rd_addr), 0);
        waitCycle();
        waitCycle();
        applyStimulus(1'b0, 1'b0);
        idle_rises = 0;
        prev = o_clk;
        for (int i = 0; i < 10; i++) begin
            waitCycle();
            if (o_clk && !prev) idle_rises++;
            prev = o_clk;
        end
        checkOutput("rst_idle_rises", idle_rises, 0);
        checkOutput("rst_idle_oe", int'(o_oe), 1);

        // Run to row 5 bitplane 3, then drop i_en at SHIFT cycle 50.
        applyStimulus(1'b0, 1'b1);
        waitCycle();
        for (int p = 0; p < 43; p++) watchPlane();
        checkOutput("drop_start_addr", addr0, 320);
        drop_at = 50;
        watchPlane();
        drop_at = -1;
        checkOutput("drop_rises", rises, 64);
        checkOutput("drop_oe_low", oe_low, 32);
        checkOutput("drop_lat_addr", lat_addr, 5);
        idle_rises = 0;
        prev = o_clk;
        for (int i = 0; i < 5; i++) begin
            waitCycle();
            if (o_clk && !prev) idle_rises++;
            prev = o_clk;
        end
        checkOutput("drop_idle_rises", idle_rises, 0);
        checkOutput("drop_idle_oe", int'(o_oe), 1);

        applyStimulus(1'b0, 1'b1);
        waitCycle();
        watchPlane();
        checkOutput("restart_rd_addr", addr0, 0);
        checkOutput("restart_oe_low", oe_low, 4);
        checkOutput("restart_lat_addr", lat_addr, 0);
        checkOutput("restart_rises", rises, 64);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
